cola_llamadas_piso: RTL and testbench

// - Producer side of the destination interface: captures floor call buttons, queues them FIFO, presents head as destino.
// - Consumer is the car controller: its puertas_abiertas rising edge marks head floor served -> pop.
// - Floors 2-bit coded: 00=-1, 01=1, 10=2, 11=3. Max one queued entry per floor.

---
 rtl/cola_llamadas_piso.sv | 67 ++++++
 tb/tb_cola_llamadas_piso.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cola_llamadas_piso.sv
// cola_llamadas_piso: floor-call FIFO feeding destinations to the car controller
module cola_llamadas_piso #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        boton,
  input  logic [1:0]        piso_actual,
  input  logic              puertas_abiertas,
  output logic [1:0]        destino,
  output logic              destino_valido,
  output logic [3:0]        pendientes,
  output logic [ADDR_W:0]   cuenta,
  output logic              lleno,
  output logic              vacio
);
  logic [3:0]        s1, s2, prev, solicitud, press, accept, cand, pick, served;
  logic [1:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]        sel;
  logic              door_prev, pop, push;
  assign vacio          = cuenta == '0;
  assign lleno          = cuenta == (ADDR_W+1)'(DEPTH);
  assign destino_valido = !vacio;
  assign destino        = vacio ? piso_actual : mem[rd_ptr];
  assign press          = s2 & ~prev;
  assign cand           = solicitud & ~pendientes;
  assign sel            = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
  assign pop            = puertas_abiertas & ~door_prev & destino_valido;
  assign push           = |cand & (!lleno | pop);
  assign pick           = push ? 4'b1 << sel : 4'b0;
  assign served         = pop ? 4'b1 << mem[rd_ptr] : 4'b0;
  // presses are dropped if already queued or for the floor whose doors are open
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++)
      accept[i] = press[i] & ~pendientes[i] & ~(puertas_abiertas && piso_actual == 2'(i));
  end
  // synchronizers, call latching and queue state
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      door_prev  <= 1'b0;
      solicitud  <= '0;
      pendientes <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cuenta     <= '0;
    end else begin
      s1         <= boton;
      s2         <= s1;
      prev       <= s2;
      door_prev  <= puertas_abiertas;
      solicitud  <= (solicitud | accept) & ~pick;
      pendientes <= (pendientes & ~served) | pick;
      if (push) begin
        mem[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cuenta <= cuenta + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  end
endmodule

// File: tb/tb_cola_llamadas_piso.sv
// tb_cola_llamadas_piso: scoreboard bench against a queue-based call model
module tb_cola_llamadas_piso;
  logic       clk = 0, rst = 1, puertas_abiertas = 0;
  logic [3:0] boton = '0;
  logic [1:0] piso_actual = 2'b01;
  logic [1:0] destino;
  logic       destino_valido, lleno, vacio;
  logic [3:0] pendientes;
  logic [2:0] cuenta;

  cola_llamadas_piso dut (
    .clk(clk), .rst(rst), .boton(boton), .piso_actual(piso_actual),
    .puertas_abiertas(puertas_abiertas), .destino(destino),
    .destino_valido(destino_valido), .pendientes(pendientes),
    .cuenta(cuenta), .lleno(lleno), .vacio(vacio)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] destino;
    logic       valido;
    logic [3:0] pend;
    logic [2:0] cuenta;
    logic       lleno;
    logic       vacio;
  } exp_t;

  exp_t sb[$];
  int   compared = 0, mismatched = 0;

  // model state: queued floors in service order, latched calls, button history
  int         q[$];
  logic [3:0] sol = '0, h1 = '0, h2 = '0, h3 = '0;
  logic       dprev = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: one step per rising edge, expected outputs pushed to the scoreboard
  always @(posedge clk) begin : model
    logic [3:0] pend, press, acc, cand;
    logic       pop, push;
    int         sel;
    exp_t       e;
    if (rst) begin
      q.delete();
      sol = '0; h1 = '0; h2 = '0; h3 = '0; dprev = 0;
    end else begin
      pend = '0;
      foreach (q[j]) pend[q[j]] = 1'b1;
      press = h2 & ~h3;
      pop = puertas_abiertas && !dprev && q.size() > 0;
      acc = '0;
      for (int i = 0; i < 4; i++)
        acc[i] = press[i] && !pend[i] && !(puertas_abiertas && piso_actual == i);
      cand = sol & ~pend;
      sel = -1;
      for (int i = 3; i >= 0; i--) if (cand[i]) sel = i;
      push = sel >= 0 && (q.size() < 4 || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(sel);
      sol = sol | acc;
      if (push) sol[sel] = 1'b0;
      h3 = h2; h2 = h1; h1 = boton;
      dprev = puertas_abiertas;
    end
    e.pend = '0;
    foreach (q[j]) e.pend[q[j]] = 1'b1;
    e.cuenta  = 3'(q.size());
    e.vacio   = q.size() == 0;
    e.lleno   = q.size() == 4;
    e.valido  = q.size() != 0;
    e.destino = e.vacio ? piso_actual : 2'(q[0]);
    sb.push_back(e);
  end

  // monitor: compare DUT state against the oldest expectation just after each edge
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("destino", 8'(destino), 8'(e.destino));
      chk("destino_valido", 8'(destino_valido), 8'(e.valido));
      chk("pendientes", 8'(pendientes), 8'(e.pend));
      chk("cuenta", 8'(cuenta), 8'(e.cuenta));
      chk("lleno", 8'(lleno), 8'(e.lleno));
      chk("vacio", 8'(vacio), 8'(e.vacio));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    rst = 0;
    cyc(20);
    chk("idle_vacio", 8'(vacio), 8'd1);
    chk("idle_destino", 8'(destino), 8'd1);
    boton[3] = 1; cyc(5); boton = '0; cyc(6);
    chk("call3_destino", 8'(destino), 8'd3);
    puertas_abiertas = 1; cyc(1); puertas_abiertas = 0; cyc(4);
    chk("served_vacio", 8'(vacio), 8'd1);
    chk("served_pend", 8'(pendientes), 8'd0);
    boton = 4'hF; cyc(1); boton = '0; cyc(8);
    chk("all_cuenta", 8'(cuenta), 8'd4);
    chk("all_lleno", 8'(lleno), 8'd1);
    chk("all_pend", 8'(pendientes), 8'hF);
    chk("all_head", 8'(destino), 8'd0);
    boton[2] = 1; cyc(2); boton = '0; cyc(5);
    chk("dup_cuenta", 8'(cuenta), 8'd4);
    puertas_abiertas = 1; boton[0] = 1; cyc(1); puertas_abiertas = 0; cyc(2); boton = '0; cyc(6);
    chk("requeue_cuenta", 8'(cuenta), 8'd4);
    chk("requeue_head", 8'(destino), 8'd1);
    puertas_abiertas = 1; cyc(1); puertas_abiertas = 0; cyc(2);
    chk("three_cuenta", 8'(cuenta), 8'd3);
    puertas_abiertas = 1; boton[1] = 1; cyc(3); boton = '0; cyc(47); puertas_abiertas = 0; cyc(3);
    chk("held_cuenta", 8'(cuenta), 8'd2);
    chk("held_pend", 8'(pendientes), 8'b1001);
    boton[2] = 1; cyc(1); boton = '0; cyc(5);
    boton[1] = 1; cyc(1); boton = '0; cyc(2);
    rst = 1; cyc(1); rst = 0; cyc(10);
    chk("rst_cuenta", 8'(cuenta), 8'd0);
    chk("rst_pend", 8'(pendientes), 8'd0);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) boton[i] = ~boton[i];
      if ($urandom_range(0, 3) == 0) puertas_abiertas = ~puertas_abiertas;
      if ($urandom_range(0, 15) == 0) piso_actual = 2'($urandom_range(0, 3));
      rst = $urandom_range(0, 199) == 0;
      cyc(1);
    end
    rst = 0; boton = '0; puertas_abiertas = 0;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
